// File: rtl/wave_ram_ctrl.sv
// wave_ram_ctrl: 16-byte wave pattern RAM (FF30-FF3F) for sound channel 3.
// Serves channel 3 sample fetches and arbitrates CPU reads/writes against
// playback. While the channel is active, CPU accesses are redirected to the
// byte the channel is currently playing (wave_a).
// Optional build macro: WAVE_RAM_DMG_ACCESS_EN -- while the channel is
// active, CPU accesses only succeed in a cycle that coincides with a fetch;
// otherwise writes are dropped and reads return 8'hFF.
module wave_ram_ctrl (
    input  logic        clk,
    input  logic        nreset,
    input  logic [15:0] a,
    input  logic [7:0]  d_in,
    output logic [7:0]  d_out,
    output logic        d_oe,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic        ch3_active,
    input  logic [3:0]  wave_a,
    input  logic        efar_q,
    input  logic        fetch,
    output logic        fetch_ack,
    output logic [3:0]  wave_play_d
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOAD = 1'b1
    } fetch_state_t;

    fetch_state_t state_r;
    logic [7:0]   mem_r [0:15];

    logic         sel_s;
    logic         cpu_ok_s;
    logic [3:0]   idx_s;
    logic         wr_take_s;
    logic         rd_take_s;
    logic         fetch_take_s;
    logic [7:0]   rd_data_s;
    logic [7:0]   fetch_byte_s;
    logic [3:0]   play_nib_s;

    // Address decode, redirection, access gating and fetch data selection.
    always_comb begin
        sel_s        = 1'b0;
        cpu_ok_s     = 1'b1;
        idx_s        = 4'h0;
        wr_take_s    = 1'b0;
        rd_take_s    = 1'b0;
        fetch_take_s = 1'b0;
        rd_data_s    = 8'hFF;
        fetch_byte_s = 8'h00;
        play_nib_s   = 4'h0;

        sel_s = (a[15:4] == 12'hFF3);

        if (ch3_active) begin
            idx_s = wave_a;
`ifdef WAVE_RAM_DMG_ACCESS_EN
            cpu_ok_s = fetch;
`else
            cpu_ok_s = 1'b1;
`endif
        end else begin
            idx_s    = a[3:0];
            cpu_ok_s = 1'b1;
        end

        // A write always wins over a coincident read; the read is dropped.
        wr_take_s    = cpu_wr & sel_s & cpu_ok_s;
        rd_take_s    = cpu_rd & sel_s & ~cpu_wr;
        fetch_take_s = fetch & ch3_active;

        if (cpu_ok_s) begin
            rd_data_s = mem_r[idx_s];
        end else begin
            rd_data_s = 8'hFF;
        end

        // Forward write data into the sample buffer when both hit the same byte.
        if (wr_take_s && (idx_s == wave_a)) begin
            fetch_byte_s = d_in;
        end else begin
            fetch_byte_s = mem_r[wave_a];
        end

        if (efar_q) begin
            play_nib_s = fetch_byte_s[3:0];
        end else begin
            play_nib_s = fetch_byte_s[7:4];
        end
    end

    // Wave RAM storage: never cleared, writes suppressed during reset.
    always_ff @(posedge clk) begin
        if (nreset && wr_take_s) begin
            mem_r[idx_s] <= d_in;
        end
    end

    // Fetch FSM and registered outputs for the sample and CPU read paths.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_r     <= IDLE;
            fetch_ack   <= 1'b0;
            wave_play_d <= 4'h0;
            d_oe        <= 1'b0;
            d_out       <= 8'h00;
        end else begin
            case (state_r)
                IDLE: begin
                    if (fetch_take_s) begin
                        state_r <= LOAD;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                LOAD: begin
                    if (fetch_take_s) begin
                        state_r <= LOAD;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase

            fetch_ack <= fetch_take_s;
            if (fetch_take_s) begin
                wave_play_d <= play_nib_s;
            end

            d_oe <= rd_take_s;
            if (rd_take_s) begin
                d_out <= rd_data_s;
            end
        end
    end

endmodule

// File: tb/tb_wave_ram_ctrl.sv
// Scoreboard bench for wave_ram_ctrl. Works in both builds: expectations for
// active-channel CPU accesses follow WAVE_RAM_DMG_ACCESS_EN when defined.
module tb_wave_ram_ctrl;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic [15:0] a = 16'h0000;
    logic [7:0]  d_in = 8'h00;
    logic [7:0]  d_out;
    logic        d_oe;
    logic        cpu_rd = 1'b0;
    logic        cpu_wr = 1'b0;
    logic        ch3_active = 1'b0;
    logic [3:0]  wave_a = 4'h0;
    logic        efar_q = 1'b0;
    logic        fetch = 1'b0;
    logic        fetch_ack;
    logic [3:0]  wave_play_d;

    wave_ram_ctrl dut (
        .clk(clk), .nreset(nreset), .a(a), .d_in(d_in), .d_out(d_out),
        .d_oe(d_oe), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
        .ch3_active(ch3_active), .wave_a(wave_a), .efar_q(efar_q),
        .fetch(fetch), .fetch_ack(fetch_ack), .wave_play_d(wave_play_d)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [7:0] val;
    } exp_t;

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    exp_t       rd_q[$];
    exp_t       fe_q[$];
    logic [7:0] mem_m [16];
    logic [3:0] last_play = 4'h0;

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    always @(posedge clk) cyc++;

    // Scoreboard: compare DUT outputs against queued expectations.
    always @(negedge clk) begin
        exp_t e;
        if (d_oe) begin
            if (rd_q.size() == 0) begin
                check_val("rd_unexpected", {7'b0, d_oe}, 8'h00);
            end else begin
                e = rd_q.pop_front();
                check_val("rd_cycle", 8'(cyc), 8'(e.cyc));
                check_val("rd_data", d_out, e.val);
            end
        end else if (rd_q.size() > 0 && rd_q[0].cyc <= cyc) begin
            void'(rd_q.pop_front());
            check_val("rd_missing", {7'b0, d_oe}, 8'h01);
        end
        if (fetch_ack) begin
            if (fe_q.size() == 0) begin
                check_val("ack_unexpected", {7'b0, fetch_ack}, 8'h00);
            end else begin
                e = fe_q.pop_front();
                check_val("fe_cycle", 8'(cyc), 8'(e.cyc));
                check_val("fe_data", {4'h0, wave_play_d}, e.val);
            end
        end else if (fe_q.size() > 0 && fe_q[0].cyc <= cyc) begin
            void'(fe_q.pop_front());
            check_val("ack_missing", {7'b0, fetch_ack}, 8'h01);
        end
    end

    function automatic logic [3:0] nib_of(input logic [7:0] b, input logic ef);
        return ef ? b[3:0] : b[7:4];
    endfunction

    // Reference write rule: decode, redirection and optional gating.
    task automatic model_write(input logic [15:0] addr, input logic [7:0] data, input logic fe);
        if (addr[15:4] == 12'hFF3) begin
            if (!ch3_active) begin
                mem_m[addr[3:0]] = data;
            end else begin
`ifdef WAVE_RAM_DMG_ACCESS_EN
                if (fe) mem_m[wave_a] = data;
`else
                mem_m[wave_a] = data;
`endif
            end
        end
    endtask

    task automatic cpu_write(input logic [15:0] addr, input logic [7:0] data);
        a = addr; d_in = data; cpu_wr = 1'b1;
        model_write(addr, data, 1'b0);
        @(posedge clk); #1;
        cpu_wr = 1'b0;
    endtask

    task automatic cpu_read(input logic [15:0] addr);
        logic [7:0] v;
        a = addr; cpu_rd = 1'b1;
        if (addr[15:4] == 12'hFF3) begin
            if (!ch3_active) v = mem_m[addr[3:0]];
            else begin
`ifdef WAVE_RAM_DMG_ACCESS_EN
                v = 8'hFF;
`else
                v = mem_m[wave_a];
`endif
            end
            rd_q.push_back('{cyc + 1, v});
        end
        @(posedge clk); #1;
        cpu_rd = 1'b0;
    endtask

    task automatic do_fetch(input logic [3:0] wa, input logic ef);
        wave_a = wa; efar_q = ef; fetch = 1'b1;
        if (ch3_active) begin
            last_play = nib_of(mem_m[wa], ef);
            fe_q.push_back('{cyc + 1, {4'h0, last_play}});
        end
        @(posedge clk); #1;
        fetch = 1'b0;
    endtask

    task automatic wr_fetch(input logic [15:0] addr, input logic [7:0] data,
                            input logic [3:0] wa, input logic ef);
        wave_a = wa; efar_q = ef; fetch = 1'b1;
        a = addr; d_in = data; cpu_wr = 1'b1;
        model_write(addr, data, 1'b1);
        last_play = nib_of(mem_m[wa], ef);
        fe_q.push_back('{cyc + 1, {4'h0, last_play}});
        @(posedge clk); #1;
        fetch = 1'b0; cpu_wr = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_ack", {7'b0, fetch_ack}, 8'h00);
        check_val("rst_play", {4'h0, wave_play_d}, 8'h00);
        check_val("rst_oe", {7'b0, d_oe}, 8'h00);
        check_val("rst_dout", d_out, 8'h00);
        @(posedge clk); #1;
        nreset = 1'b1;

        // Inactive write of all 16 bytes, then read-back
        for (int i = 0; i < 16; i++) cpu_write(16'hFF30 + 16'(i), 8'(i + 1));
        cpu_read(16'hFF35);
        cpu_read(16'hFF3F);
        cpu_read(16'hFF40);
        cpu_write(16'hFE35, 8'h77);
        cpu_read(16'hFF35);

        // Simultaneous read and write: write wins, no read response
        a = 16'hFF32; d_in = 8'h55; cpu_wr = 1'b1; cpu_rd = 1'b1;
        model_write(16'hFF32, 8'h55, 1'b0);
        @(posedge clk); #1;
        cpu_wr = 1'b0; cpu_rd = 1'b0;
        cpu_read(16'hFF32);

        // Fetch both nibbles of A5
        cpu_write(16'hFF33, 8'hA5);
        ch3_active = 1'b1;
        do_fetch(4'd3, 1'b0);
        do_fetch(4'd3, 1'b1);
        @(posedge clk); #1;

        // Back-to-back fetches, one update per cycle
        for (int i = 0; i < 4; i++) do_fetch(4'(i), 1'(i));

        // Inactive fetch ignored, output held
        ch3_active = 1'b0;
        repeat (3) @(posedge clk); #1;
        check_val("hold_play", {4'h0, wave_play_d}, {4'h0, last_play});
        do_fetch(4'd5, 1'b1);
        @(posedge clk); #1;
        check_val("hold_play2", {4'h0, wave_play_d}, {4'h0, last_play});

        // Redirection while active
        ch3_active = 1'b1; wave_a = 4'd7;
        cpu_read(16'hFF30);
        cpu_write(16'hFF30, 8'h3C);
        ch3_active = 1'b0;
        cpu_read(16'hFF37);
        cpu_read(16'hFF30);

        // Write coincident with fetch: forwarded to the sample
        ch3_active = 1'b1;
        wr_fetch(16'hFF30, 8'h9E, 4'd7, 1'b0);
        ch3_active = 1'b0;
        cpu_read(16'hFF37);
        cpu_read(16'hFF30);

        // Reset arriving in the cycle after a fetch
        ch3_active = 1'b1;
        do_fetch(4'd3, 1'b0);
        nreset = 1'b0;
        @(posedge clk); #1;
        check_val("rstmid_ack", {7'b0, fetch_ack}, 8'h00);
        check_val("rstmid_play", {4'h0, wave_play_d}, 8'h00);
        last_play = 4'h0;
        nreset = 1'b1; ch3_active = 1'b0;
        cpu_read(16'hFF33);
        cpu_read(16'hFF3F);

        repeat (3) @(posedge clk); #1;
        check_val("rd_q_empty", 8'(rd_q.size()), 8'h00);
        check_val("fe_q_empty", 8'(fe_q.size()), 8'h00);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
